rle_stream_ctrl: RTL and testbench
==================================

// Module: rle_stream_ctrl
// PURPOSE
//  Sequences the RLE compression datapath behind the HPS PIO handshake signals
//  (odata, write_req, in_full, read_req, idata, result_ready, flush, rle_reset).
//  Edge-detects HPS requests, buffers input bytes and output run words in FIFOs,
//  feeds the RLE encoder, and runs the flush sequence. Sits in the FPGA top
//  level between Computer_System PIO exports and the rle encoder core.
// PARAMETERS
//  IN_DEPTH       16    input byte FIFO depth (power of 2)
//  OUT_DEPTH      16    output word FIFO depth (power of 2)
//  FLUSH_TIMEOUT  1024  max cycles in FLUSH_WAIT before abort
// PORTS
//  clk              in   1   system clock; all inputs synchronous to it
//  reset            in   1   synchronous, active-high
//  hps_odata        in   8   byte from HPS (odata PIO)
//  hps_write_req    in   1   level; rising edge = push hps_odata
//  hps_in_full      out  1   to fifo_in_full PIO
//  hps_read_req     in   1   level; rising edge = pop current result
//  hps_idata        out  24  head output word (idata PIO)
//  hps_result_ready out  1   hps_idata valid (result_ready PIO)
//  hps_flush        in   1   level; rising edge = start flush
//  hps_rle_reset    in   1   level; soft reset while high
//  enc_in_data      out  8   byte to encoder
//  enc_in_valid     out  1   valid/ready handshake to encoder
//  enc_in_ready     in   1
//  enc_out_data     in   24  {count[15:0], byte[7:0]} from encoder
//  enc_out_valid    in   1
//  enc_out_ready    out  1
//  enc_flush        out  1   one-cycle pulse: emit pending run
//  enc_flush_done   in   1   one-cycle pulse: final run emitted
//  enc_reset        out  1   = reset | hps_rle_reset, registered
//  err_overflow     out  1   sticky: write edge while hps_in_full
//  err_timeout      out  1   sticky: flush wait exceeded FLUSH_TIMEOUT
// BEHAVIOUR
//  - Reset (reset or hps_rle_reset): FIFOs emptied, state IDLE, edge regs
//    loaded with current input levels (no spurious edge), all outputs 0
//    except enc_reset=1; hps_idata=0. Sticky errors cleared only by reset/soft reset.
//  - Edge detect: one register per request; edge = in & ~prev.
//  - Write: edge & ~hps_in_full -> push hps_odata same cycle. Edge while full
//    -> byte dropped, err_overflow<=1. hps_in_full = in FIFO full | state!=IDLE.
//  - Encoder feed: enc_in_valid = in FIFO non-empty (FWFT head on enc_in_data);
//    pop on valid&ready. Byte pushed cycle N reaches enc_in_data at N+1 earliest.
//  - Output: enc_out_ready = ~out FIFO full; push on valid&ready.
//    hps_idata/hps_result_ready registered from out FIFO head: word pushed at N
//    visible at N+2. Read edge with result_ready=1 pops; next head (or
//    result_ready=0) at edge+1. Read edge with result_ready=0 ignored.
//  - Simultaneous push/pop on either FIFO at full or empty is legal; count unchanged.
//  - FSM: IDLE -flush edge-> DRAIN -in FIFO empty-> FLUSH_REQ (enc_flush=1,
//    one cycle) -> WAIT -enc_flush_done-> IDLE. WAIT counter reaching
//    FLUSH_TIMEOUT-1 -> err_timeout<=1, IDLE. Flush edge outside IDLE ignored.
//    Output draining continues in all states.
//  - Soft reset mid-flush aborts to IDLE within 1 cycle; no enc_flush issued after.
// STRUCTURE
//  - rle_pkg: state enum {IDLE,DRAIN,FLUSH_REQ,WAIT}, BYTE_W=8, WORD_W=24,
//    COUNT_W=16.
//  - Sub-module sync_fifo #(WIDTH,DEPTH), FWFT, full/empty flags; instanced
//    twice (in: 8b x IN_DEPTH, out: 24b x OUT_DEPTH). FSM/edge/CDC-free glue
//    in this file.
// TESTING
//  - Push 0x41 x5 then 0x42 x3, flush edge; encoder model -> results
//    0x000541, 0x000342 in order, result_ready falls after 2 read edges.
//  - 17 write edges with enc_in_ready=0, IN_DEPTH=16 -> hps_in_full=1 after
//    16th, err_overflow=1 after 17th, FIFO holds first 16 bytes.
//  - enc_out_valid held 1 with no read edges -> enc_out_ready=0 after 16 words;
//    one read edge -> exactly one further word accepted.
//  - Flush with enc_flush_done never pulsed -> err_timeout=1 at cycle 1024 of
//    WAIT, state IDLE, hps_in_full=0.
//  - hps_rle_reset pulsed during DRAIN with 4 bytes queued -> FIFOs empty,
//    result_ready=0, enc_flush never asserted, enc_reset=1 during pulse.
//  - Read edge with result_ready=0 and write_req held high 10 cycles -> no
//    pop, single push only.

Source files
------------

// File: rtl/rle_pkg.sv
// rle_pkg
//   Shared constants for the RLE stream controller: datapath widths and the
//   flush-sequencer state encoding.
//   Run words are {count[COUNT_W-1:0], byte[BYTE_W-1:0]}.
package rle_pkg;

  localparam int BYTE_W  = 8;
  localparam int COUNT_W = 16;
  localparam int WORD_W  = COUNT_W + BYTE_W;

  // Flush sequencer states.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_DRAIN     = 2'd1;
  localparam state_t ST_FLUSH_REQ = 2'd2;
  localparam state_t ST_WAIT      = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock first-word-fall-through FIFO. The head entry is always
//   presented on rd_data. The entry behind the head is presented on
//   rd_next_data, so a consumer that registers the head can load the
//   following entry in the same cycle it pops.
// Ports
//   clk, srst     clock and synchronous active-high clear
//   wr_en/wr_data push request; ignored when full unless a pop happens too
//   rd_en         pop request; ignored when empty
//   rd_data       head entry (meaningless when empty)
//   rd_next_data  entry behind the head (meaningless unless 2+ entries)
//   full/empty    occupancy flags; single = exactly one entry held
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] rd_next_data,
  output logic             full,
  output logic             empty,
  output logic             single
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_ptr_nx;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign single       = (count_q == CW'(1));
  assign rd_ptr_nx    = rd_ptr_q + AW'(1);
  assign rd_data      = mem_q[rd_ptr_q];
  assign rd_next_data = mem_q[rd_ptr_nx];

  always_comb begin
    do_rd    = rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    do_wr    = wr_en & (~full | do_rd);
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    count_d  = count_q + CW'(do_wr) - CW'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rle_stream_ctrl.sv
// rle_stream_ctrl
//   Glue between the HPS PIO handshake lines and the RLE encoder core.
//   HPS request levels are edge-detected; written bytes are queued in an
//   input FIFO that feeds the encoder, encoder run words are queued in an
//   output FIFO whose head is registered onto hps_idata/hps_result_ready,
//   and a small sequencer runs drain -> flush pulse -> wait-for-done.
// Ports
//   clk, reset                        clock, synchronous active-high reset
//   hps_odata, hps_write_req          byte + push request level from HPS
//   hps_in_full                       HPS must not write while high
//   hps_read_req                      pop request level from HPS
//   hps_idata, hps_result_ready       registered output-FIFO head + valid
//   hps_flush                         flush request level from HPS
//   hps_rle_reset                     soft reset level from HPS
//   enc_in_data/valid/ready           byte stream into the encoder
//   enc_out_data/valid/ready          run words out of the encoder
//   enc_flush, enc_flush_done         flush pulse out, completion pulse in
//   enc_reset                         registered reset to the encoder
//   err_overflow, err_timeout         sticky error flags
module rle_stream_ctrl
  import rle_pkg::*;
#(
  parameter int IN_DEPTH      = 16,
  parameter int OUT_DEPTH     = 16,
  parameter int FLUSH_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] hps_odata,
  input  logic              hps_write_req,
  output logic              hps_in_full,
  input  logic              hps_read_req,
  output logic [WORD_W-1:0] hps_idata,
  output logic              hps_result_ready,
  input  logic              hps_flush,
  input  logic              hps_rle_reset,
  output logic [BYTE_W-1:0] enc_in_data,
  output logic              enc_in_valid,
  input  logic              enc_in_ready,
  input  logic [WORD_W-1:0] enc_out_data,
  input  logic              enc_out_valid,
  output logic              enc_out_ready,
  output logic              enc_flush,
  input  logic              enc_flush_done,
  output logic              enc_reset,
  output logic              err_overflow,
  output logic              err_timeout
);

  localparam int TW = $clog2(FLUSH_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(FLUSH_TIMEOUT - 1);

  logic              soft_rst;
  logic              wr_prev_q, rd_prev_q, fl_prev_q;
  logic              wr_edge, rd_edge, fl_edge;
  state_t            state_q, state_d;
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic              err_overflow_q, err_overflow_d;
  logic              err_timeout_q, err_timeout_d;
  logic              result_ready_q, result_ready_d;
  logic [WORD_W-1:0] idata_q, idata_d;
  logic              enc_reset_q;

  logic              in_push, in_pop, in_full, in_empty;
  logic [BYTE_W-1:0] in_head;
  logic [BYTE_W-1:0] unused_in_next;
  logic              unused_in_single;
  logic              out_push, out_pop, out_full, out_empty, out_single;
  logic [WORD_W-1:0] out_head, out_next;

  // Hard and soft reset share one path; every combinational output is
  // forced low while either is active so nothing leaks out mid-reset.
  assign soft_rst = reset | hps_rle_reset;

  assign wr_edge = hps_write_req & ~wr_prev_q;
  assign rd_edge = hps_read_req  & ~rd_prev_q;
  assign fl_edge = hps_flush     & ~fl_prev_q;

  // Writes are refused for the whole flush sequence, not only when full.
  assign hps_in_full   = ~soft_rst & (in_full | (state_q != ST_IDLE));
  assign in_push       = ~soft_rst & wr_edge & ~hps_in_full;
  assign enc_in_valid  = ~soft_rst & ~in_empty;
  assign enc_in_data   = enc_in_valid ? in_head : '0;
  assign in_pop        = enc_in_valid & enc_in_ready;

  assign enc_out_ready = ~soft_rst & ~out_full;
  assign out_push      = enc_out_valid & enc_out_ready;
  assign out_pop       = ~soft_rst & rd_edge & result_ready_q;

  assign enc_flush        = ~soft_rst & (state_q == ST_FLUSH_REQ);
  assign enc_reset        = enc_reset_q;
  assign hps_idata        = idata_q;
  assign hps_result_ready = result_ready_q;
  assign err_overflow     = err_overflow_q;
  assign err_timeout      = err_timeout_q;

  always_comb begin
    state_d        = state_q;
    tmo_cnt_d      = tmo_cnt_q;
    err_timeout_d  = err_timeout_q;
    err_overflow_d = err_overflow_q | (wr_edge & hps_in_full);

    case (state_q)
      ST_IDLE:  if (fl_edge) state_d = ST_DRAIN;
      ST_DRAIN: if (in_empty) state_d = ST_FLUSH_REQ;
      ST_FLUSH_REQ: begin
        state_d   = ST_WAIT;
        tmo_cnt_d = '0;
      end
      ST_WAIT: begin
        if (enc_flush_done) begin
          state_d = ST_IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The registered result tracks the FIFO head. On a pop the head is
    // about to advance, so load the entry behind it directly; otherwise the
    // HPS would see the word it just consumed for one more cycle.
    if (out_pop) begin
      result_ready_d = ~out_single;
      idata_d        = out_single ? '0 : out_next;
    end else begin
      result_ready_d = ~out_empty;
      idata_d        = out_empty ? '0 : out_head;
    end
  end

  always_ff @(posedge clk) begin
    enc_reset_q <= soft_rst;
    if (soft_rst) begin
      // Load current levels so a request held through reset is not an edge.
      wr_prev_q      <= hps_write_req;
      rd_prev_q      <= hps_read_req;
      fl_prev_q      <= hps_flush;
      state_q        <= ST_IDLE;
      tmo_cnt_q      <= '0;
      err_overflow_q <= 1'b0;
      err_timeout_q  <= 1'b0;
      result_ready_q <= 1'b0;
      idata_q        <= '0;
    end else begin
      wr_prev_q      <= hps_write_req;
      rd_prev_q      <= hps_read_req;
      fl_prev_q      <= hps_flush;
      state_q        <= state_d;
      tmo_cnt_q      <= tmo_cnt_d;
      err_overflow_q <= err_overflow_d;
      err_timeout_q  <= err_timeout_d;
      result_ready_q <= result_ready_d;
      idata_q        <= idata_d;
    end
  end

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (IN_DEPTH)
  ) u_in_fifo (
    .clk          (clk),
    .srst         (soft_rst),
    .wr_en        (in_push),
    .wr_data      (hps_odata),
    .rd_en        (in_pop),
    .rd_data      (in_head),
    .rd_next_data (unused_in_next),
    .full         (in_full),
    .empty        (in_empty),
    .single       (unused_in_single)
  );

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk          (clk),
    .srst         (soft_rst),
    .wr_en        (out_push),
    .wr_data      (enc_out_data),
    .rd_en        (out_pop),
    .rd_data      (out_head),
    .rd_next_data (out_next),
    .full         (out_full),
    .empty        (out_empty),
    .single       (out_single)
  );

endmodule

// File: tb/tb_rle_stream_ctrl.sv
// tb_rle_stream_ctrl
//   Directed bench for rle_stream_ctrl. A small behavioural RLE encoder can
//   be switched in to answer the byte/word/flush handshakes; otherwise the
//   encoder-side inputs are driven directly by the scenario tasks.
module tb_rle_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  hps_odata = 8'h00;
  logic        hps_write_req = 1'b0;
  logic        hps_read_req = 1'b0;
  logic        hps_flush = 1'b0;
  logic        hps_rle_reset = 1'b0;
  logic        enc_in_ready = 1'b0;
  logic        hps_in_full, hps_result_ready;
  logic [23:0] hps_idata;
  logic [7:0]  enc_in_data;
  logic        enc_in_valid, enc_out_ready, enc_flush, enc_reset;
  logic        err_overflow, err_timeout;

  logic        model_en = 1'b0;
  logic        done_en = 1'b0;
  logic        drv_out_valid = 1'b0;
  logic [23:0] drv_out_data = 24'h0;
  logic        mdl_out_valid = 1'b0;
  logic [23:0] mdl_out_data = 24'h0;
  logic        mdl_flush_done = 1'b0;
  logic        enc_out_valid, enc_flush_done;
  logic [23:0] enc_out_data;

  assign enc_out_valid  = model_en ? mdl_out_valid : drv_out_valid;
  assign enc_out_data   = model_en ? mdl_out_data  : drv_out_data;
  assign enc_flush_done = mdl_flush_done;

  int n_cmp = 0;
  int n_err = 0;
  int flush_pulses = 0;

  rle_stream_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .hps_odata        (hps_odata),
    .hps_write_req    (hps_write_req),
    .hps_in_full      (hps_in_full),
    .hps_read_req     (hps_read_req),
    .hps_idata        (hps_idata),
    .hps_result_ready (hps_result_ready),
    .hps_flush        (hps_flush),
    .hps_rle_reset    (hps_rle_reset),
    .enc_in_data      (enc_in_data),
    .enc_in_valid     (enc_in_valid),
    .enc_in_ready     (enc_in_ready),
    .enc_out_data     (enc_out_data),
    .enc_out_valid    (enc_out_valid),
    .enc_out_ready    (enc_out_ready),
    .enc_flush        (enc_flush),
    .enc_flush_done   (enc_flush_done),
    .enc_reset        (enc_reset),
    .err_overflow     (err_overflow),
    .err_timeout      (err_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (enc_flush === 1'b1) flush_pulses++;
  end

  // Behavioural encoder: extends the current run, emits {count,byte} when
  // the byte changes, emits the pending run on enc_flush and answers with a
  // one-cycle enc_flush_done when done_en is set.
  logic [23:0] mq[$];
  logic [7:0]  run_byte = 8'h00;
  int          run_cnt = 0;

  always begin : enc_model
    logic in_fire, out_fire, fl_seen, rst_seen;
    logic [7:0] b;
    @(posedge clk);
    in_fire  = enc_in_valid && enc_in_ready;
    out_fire = enc_out_valid && enc_out_ready;
    fl_seen  = enc_flush;
    rst_seen = reset || hps_rle_reset;
    b        = enc_in_data;
    #1;
    mdl_flush_done = 1'b0;
    if (!model_en || rst_seen) begin
      mq.delete();
      run_cnt = 0;
    end else begin
      if (out_fire && mq.size() > 0) void'(mq.pop_front());
      if (in_fire) begin
        if (run_cnt > 0 && b == run_byte && run_cnt < 65535) begin
          run_cnt++;
        end else begin
          if (run_cnt > 0) mq.push_back({16'(run_cnt), run_byte});
          run_byte = b;
          run_cnt  = 1;
        end
      end
      if (fl_seen) begin
        if (run_cnt > 0) mq.push_back({16'(run_cnt), run_byte});
        run_cnt = 0;
        mdl_flush_done = done_en;
      end
    end
    mdl_out_valid = (mq.size() > 0);
    mdl_out_data  = (mq.size() > 0) ? mq[0] : 24'h0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    hps_write_req = 1'b0; hps_read_req = 1'b0; hps_flush = 1'b0;
    hps_rle_reset = 1'b0; enc_in_ready = 1'b0; drv_out_valid = 1'b0;
    drv_out_data = 24'h0; model_en = 1'b0; done_en = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic write_byte(input logic [7:0] b);
    hps_odata = b;
    hps_write_req = 1'b1;
    tick();
    hps_write_req = 1'b0;
    tick();
    $display("write %02h -> in_full=%0b err_overflow=%0b", b, hps_in_full, err_overflow);
  endtask

  task automatic flush_edge();
    hps_flush = 1'b1;
    tick();
    hps_flush = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    hps_write_req = 1'b1;
    reset = 1'b1;
    tick(); tick();
    n_cmp++; if (enc_reset !== 1'b1) begin n_err++; $display("FAIL rst_enc_reset: got %0b want 1", enc_reset); end
    n_cmp++; if (hps_result_ready !== 1'b0 || hps_idata !== 24'h0) begin n_err++; $display("FAIL rst_result: got ready=%0b idata=%h want 0/000000", hps_result_ready, hps_idata); end
    n_cmp++; if ({hps_in_full, enc_in_valid, enc_out_ready, enc_flush} !== 4'b0) begin n_err++; $display("FAIL rst_outputs: got %b want 0000", {hps_in_full, enc_in_valid, enc_out_ready, enc_flush}); end
    reset = 1'b0;
    tick();
    n_cmp++; if (enc_reset !== 1'b0) begin n_err++; $display("FAIL rel_enc_reset: got %0b want 0", enc_reset); end
    n_cmp++; if (enc_out_ready !== 1'b1 || hps_in_full !== 1'b0) begin n_err++; $display("FAIL rel_ready: got out_ready=%0b in_full=%0b want 1/0", enc_out_ready, hps_in_full); end
    n_cmp++; if (err_overflow !== 1'b0 || err_timeout !== 1'b0) begin n_err++; $display("FAIL rel_errors: got %0b%0b want 00", err_overflow, err_timeout); end
    tick();
    n_cmp++; if (enc_in_valid !== 1'b0) begin n_err++; $display("FAIL rel_no_spurious_push: got valid=%0b want 0", enc_in_valid); end
    hps_write_req = 1'b0;
    tick();
    $display("reset test done");
  endtask

  task automatic test_encode();
    int f0;
    do_reset();
    model_en = 1'b1; done_en = 1'b1; enc_in_ready = 1'b1;
    f0 = flush_pulses;
    repeat (5) write_byte(8'h41);
    repeat (3) write_byte(8'h42);
    flush_edge();
    for (int i = 0; i < 200 && hps_result_ready !== 1'b1; i++) tick();
    n_cmp++; if (hps_result_ready !== 1'b1) begin n_err++; $display("FAIL enc_result_wait: got ready=%0b want 1", hps_result_ready); end
    n_cmp++; if (hps_idata !== 24'h000541) begin n_err++; $display("FAIL enc_word0: got %h want 000541", hps_idata); end
    repeat (10) tick();
    n_cmp++; if (hps_in_full !== 1'b0) begin n_err++; $display("FAIL enc_back_idle: got in_full=%0b want 0", hps_in_full); end
    n_cmp++; if (flush_pulses - f0 !== 1) begin n_err++; $display("FAIL enc_flush_count: got %0d want 1", flush_pulses - f0); end
    hps_read_req = 1'b1;
    tick();
    $display("read -> ready=%0b idata=%h", hps_result_ready, hps_idata);
    n_cmp++; if (hps_result_ready !== 1'b1 || hps_idata !== 24'h000342) begin n_err++; $display("FAIL enc_word1: got ready=%0b idata=%h want 1/000342", hps_result_ready, hps_idata); end
    hps_read_req = 1'b0;
    tick();
    hps_read_req = 1'b1;
    tick();
    $display("read -> ready=%0b idata=%h", hps_result_ready, hps_idata);
    n_cmp++; if (hps_result_ready !== 1'b0) begin n_err++; $display("FAIL enc_ready_fall: got %0b want 0", hps_result_ready); end
    hps_read_req = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      b = 8'h10 + 8'(i);
      write_byte(b);
      if (i == 14) begin
        n_cmp++; if (hps_in_full !== 1'b0) begin n_err++; $display("FAIL ovf_not_full_15: got %0b want 0", hps_in_full); end
      end
    end
    n_cmp++; if (hps_in_full !== 1'b1) begin n_err++; $display("FAIL ovf_full_16: got %0b want 1", hps_in_full); end
    n_cmp++; if (err_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_no_err_16: got %0b want 0", err_overflow); end
    write_byte(8'hEE);
    n_cmp++; if (err_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_err_17: got %0b want 1", err_overflow); end
    enc_in_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b = 8'h10 + 8'(i);
      n_cmp++; if (enc_in_valid !== 1'b1 || enc_in_data !== b) begin n_err++; $display("FAIL ovf_content[%0d]: got valid=%0b data=%h want 1/%h", i, enc_in_valid, enc_in_data, b); end
      tick();
    end
    n_cmp++; if (enc_in_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drained: got valid=%0b want 0", enc_in_valid); end
    enc_in_ready = 1'b0;
  endtask

  task automatic test_out_full();
    int acc;
    do_reset();
    acc = 0;
    drv_out_valid = 1'b1;
    drv_out_data = 24'hA00000;
    for (int i = 0; i < 30; i++) begin
      if (enc_out_ready === 1'b1) acc++;
      tick();
      drv_out_data = 24'hA00000 + 24'(acc);
    end
    n_cmp++; if (acc !== 16 || enc_out_ready !== 1'b0) begin n_err++; $display("FAIL out_full: got accepted=%0d ready=%0b want 16/0", acc, enc_out_ready); end
    n_cmp++; if (hps_result_ready !== 1'b1 || hps_idata !== 24'hA00000) begin n_err++; $display("FAIL out_head: got ready=%0b idata=%h want 1/a00000", hps_result_ready, hps_idata); end
    hps_read_req = 1'b1;
    if (enc_out_ready === 1'b1) acc++;
    tick();
    drv_out_data = 24'hA00000 + 24'(acc);
    hps_read_req = 1'b0;
    $display("read -> ready=%0b idata=%h", hps_result_ready, hps_idata);
    n_cmp++; if (hps_idata !== 24'hA00001) begin n_err++; $display("FAIL out_next_head: got %h want a00001", hps_idata); end
    for (int i = 0; i < 10; i++) begin
      if (enc_out_ready === 1'b1) acc++;
      tick();
      drv_out_data = 24'hA00000 + 24'(acc);
    end
    n_cmp++; if (acc !== 17) begin n_err++; $display("FAIL out_one_more: got accepted=%0d want 17", acc); end
    drv_out_valid = 1'b0;
  endtask

  task automatic test_timeout();
    int fl_idx, to_idx, f0;
    logic full_before, full_after;
    do_reset();
    model_en = 1'b1; done_en = 1'b0; enc_in_ready = 1'b1;
    f0 = flush_pulses;
    fl_idx = -1; to_idx = -1; full_before = 1'bx; full_after = 1'bx;
    hps_flush = 1'b1;
    tick();
    hps_flush = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (enc_flush === 1'b1 && fl_idx < 0) fl_idx = i;
      if (fl_idx >= 0 && i == fl_idx + 1024) full_before = hps_in_full;
      if (err_timeout === 1'b1) begin
        to_idx = i;
        full_after = hps_in_full;
        break;
      end
      tick();
    end
    $display("flush at %0d, timeout at %0d", fl_idx, to_idx);
    n_cmp++; if (fl_idx < 0 || to_idx - fl_idx !== 1025) begin n_err++; $display("FAIL tmo_latency: got flush=%0d timeout=%0d want distance 1025", fl_idx, to_idx); end
    n_cmp++; if (full_before !== 1'b1) begin n_err++; $display("FAIL tmo_busy_in_wait: got %0b want 1", full_before); end
    n_cmp++; if (full_after !== 1'b0) begin n_err++; $display("FAIL tmo_idle_after: got %0b want 0", full_after); end
    tick();
    n_cmp++; if (err_timeout !== 1'b1 || flush_pulses - f0 !== 1) begin n_err++; $display("FAIL tmo_sticky: got err=%0b pulses=%0d want 1/1", err_timeout, flush_pulses - f0); end
  endtask

  task automatic test_soft_reset();
    int f0;
    do_reset();
    drv_out_valid = 1'b1; drv_out_data = 24'h123456;
    tick(); tick();
    drv_out_valid = 1'b0;
    tick(); tick();
    n_cmp++; if (hps_result_ready !== 1'b1) begin n_err++; $display("FAIL srst_pre_ready: got %0b want 1", hps_result_ready); end
    for (int i = 1; i <= 4; i++) write_byte(8'(i));
    f0 = flush_pulses;
    flush_edge();
    n_cmp++; if (hps_in_full !== 1'b1 || enc_in_valid !== 1'b1) begin n_err++; $display("FAIL srst_in_drain: got in_full=%0b valid=%0b want 1/1", hps_in_full, enc_in_valid); end
    hps_rle_reset = 1'b1;
    tick();
    n_cmp++; if (enc_reset !== 1'b1) begin n_err++; $display("FAIL srst_enc_reset: got %0b want 1", enc_reset); end
    tick();
    hps_rle_reset = 1'b0;
    tick();
    n_cmp++; if (enc_reset !== 1'b0) begin n_err++; $display("FAIL srst_enc_reset_rel: got %0b want 0", enc_reset); end
    n_cmp++; if ({enc_in_valid, hps_result_ready, hps_in_full} !== 3'b000) begin n_err++; $display("FAIL srst_cleared: got valid/ready/in_full=%b want 000", {enc_in_valid, hps_result_ready, hps_in_full}); end
    enc_in_ready = 1'b1;
    repeat (20) tick();
    n_cmp++; if (flush_pulses !== f0) begin n_err++; $display("FAIL srst_no_flush: got %0d pulses want 0", flush_pulses - f0); end
    enc_in_ready = 1'b0;
  endtask

  task automatic test_read_ignored();
    do_reset();
    hps_read_req = 1'b1;
    tick();
    hps_odata = 8'h5A;
    hps_write_req = 1'b1;
    repeat (10) tick();
    hps_write_req = 1'b0;
    tick();
    n_cmp++; if (enc_in_valid !== 1'b1 || enc_in_data !== 8'h5A) begin n_err++; $display("FAIL hold_push: got valid=%0b data=%h want 1/5a", enc_in_valid, enc_in_data); end
    enc_in_ready = 1'b1;
    tick();
    enc_in_ready = 1'b0;
    n_cmp++; if (enc_in_valid !== 1'b0) begin n_err++; $display("FAIL hold_single_push: got valid=%0b want 0", enc_in_valid); end
    drv_out_valid = 1'b1; drv_out_data = 24'h0BEEF0;
    tick();
    drv_out_valid = 1'b0;
    tick(); tick();
    n_cmp++; if (hps_result_ready !== 1'b1 || hps_idata !== 24'h0BEEF0) begin n_err++; $display("FAIL ignored_read_no_pop: got ready=%0b idata=%h want 1/0beef0", hps_result_ready, hps_idata); end
    hps_read_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_encode();
    test_overflow();
    test_out_full();
    test_timeout();
    test_soft_reset();
    test_read_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
